// File: rtl/fetch_top.sv
// Fetch stage: owns the fetch PC, requests words over req/ack, and registers
// {pc, instruction, valid} into decode with a one-entry skid buffer for stalls.
module fetch_top #(
  parameter int ADDR_SIZE  = 32,
  parameter int INSTR_SIZE = 32,
  parameter logic [ADDR_SIZE-1:0] RESET_PC = 32'h00001000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  is_jump,
  input  logic [ADDR_SIZE-1:0]  jump_addr,
  input  logic                  branch_taken,
  input  logic [ADDR_SIZE-1:0]  branch_addr,
  output logic                  imem_req,
  output logic [ADDR_SIZE-1:0]  imem_addr,
  input  logic                  imem_ack,
  input  logic [INSTR_SIZE-1:0] imem_data,
  output logic [ADDR_SIZE-1:0]  out_pc,
  output logic [INSTR_SIZE-1:0] out_instruction,
  output logic                  out_valid
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;

  typedef struct packed {
    logic [ADDR_SIZE-1:0]  pc;
    logic [INSTR_SIZE-1:0] instr;
  } entry_t;

  state_t               state;
  logic [ADDR_SIZE-1:0] req_addr;
  logic [ADDR_SIZE-1:0] tgt_reg;
  entry_t               skid;

  logic                 redirect;
  logic [ADDR_SIZE-1:0] target;
  logic [ADDR_SIZE-1:0] next_addr;

  // Redirects during a stall are dropped; decode re-presents the jump later.
  assign redirect  = (branch_taken | is_jump) & ~stall;
  assign target    = branch_taken ? branch_addr : jump_addr;
  assign next_addr = req_addr + ADDR_SIZE'(4);

  assign imem_req  = (state == RUN) || (state == DRAIN);
  assign imem_addr = req_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      req_addr        <= RESET_PC;
      tgt_reg         <= '0;
      skid            <= '0;
      out_pc          <= '0;
      out_instruction <= '0;
      out_valid       <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= RUN;

        RUN: begin
          if (redirect) begin
            out_valid <= 1'b0;
            if (imem_ack) begin
              req_addr <= target;
            end else begin
              // Request must stay stable until acked; park the target.
              tgt_reg <= target;
              state   <= DRAIN;
            end
          end else if (imem_ack) begin
            req_addr <= next_addr;
            if (!stall) begin
              out_pc          <= req_addr;
              out_instruction <= imem_data;
              out_valid       <= 1'b1;
            end else begin
              skid  <= '{pc: req_addr, instr: imem_data};
              state <= HOLD;
            end
          end else if (!stall) begin
            out_valid <= 1'b0;
          end
        end

        DRAIN: begin
          if (redirect) tgt_reg <= target;
          if (imem_ack) begin
            req_addr <= redirect ? target : tgt_reg;
            state    <= RUN;
          end
          if (!stall) out_valid <= 1'b0;
        end

        HOLD: begin
          if (!stall) begin
            state <= RUN;
            if (redirect) begin
              req_addr  <= target;
              out_valid <= 1'b0;
            end else begin
              out_pc          <= skid.pc;
              out_instruction <= skid.instr;
              out_valid       <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
